// File: rtl/wb_regfile_pkg.sv
// Shared types and sizes for the writeback stage and its register file.
package wb_pkg;
  localparam int XLEN      = 32;
  localparam int REG_COUNT = 32;
  localparam int REG_IDX_W = $clog2(REG_COUNT);

  typedef struct packed {
    logic                 valid;
    logic                 ctrl;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      val;
  } wb_entry_t;
endpackage

// File: rtl/wb_regfile_if.sv
// Writeback handshake bus between the ALU (master) and the writeback stage (slave).
interface wb_regfile_if;
  import wb_pkg::*;

  logic                 wb_valid_in;
  logic                 wb_ready_out;
  logic [REG_IDX_W-1:0] rd_addr_in;
  logic                 rd_write_control_in;
  logic [XLEN-1:0]      rd_write_val_in;

  modport master (
    output wb_valid_in, rd_addr_in, rd_write_control_in, rd_write_val_in,
    input  wb_ready_out
  );

  modport slave (
    input  wb_valid_in, rd_addr_in, rd_write_control_in, rd_write_val_in,
    output wb_ready_out
  );
endinterface

// File: rtl/wb_regfile_array.sv
// Architectural register storage: one synchronous write port, two asynchronous
// read ports, synchronous clear, x0 hard-wired to zero.
module regfile_array
  import wb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [XLEN-1:0]      wdata,
  input  logic [REG_IDX_W-1:0] raddr_a,
  output logic [XLEN-1:0]      rdata_a,
  input  logic [REG_IDX_W-1:0] raddr_b,
  output logic [XLEN-1:0]      rdata_b
);
  logic [XLEN-1:0] mem_q [REG_COUNT];
  logic [XLEN-1:0] mem_d [REG_COUNT];

  always_comb begin
    mem_d = mem_q;
    if (we && (waddr != {REG_IDX_W{1'b0}})) begin
      mem_d[waddr] = wdata;
    end else begin
      mem_d = mem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        mem_q[i] <= {XLEN{1'b0}};
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_a = (raddr_a == {REG_IDX_W{1'b0}}) ? {XLEN{1'b0}} : mem_q[raddr_a];
  assign rdata_b = (raddr_b == {REG_IDX_W{1'b0}}) ? {XLEN{1'b0}} : mem_q[raddr_b];
endmodule

// File: rtl/wb_regfile.sv
// Writeback stage register, read-port bypass and register file commit.
// Optional retired-write counter enabled by WB_RETIRE_COUNT_EN.
module wb_regfile
  import wb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  wb_regfile_if.slave          wb,
  input  logic                 wb_stall,
  input  logic [REG_IDX_W-1:0] rs1_addr,
  input  logic [REG_IDX_W-1:0] rs2_addr,
  output logic [XLEN-1:0]      rs1_val,
  output logic [XLEN-1:0]      rs2_val,
  output logic                 wb_pending,
  output logic [31:0]          retire_count
);
  wb_entry_t       stage_q, stage_d;
  logic            commit_s;
  logic [XLEN-1:0] arr_rs1_s, arr_rs2_s;

  assign wb.wb_ready_out = ~wb_stall;
  assign wb_pending      = stage_q.valid & stage_q.ctrl & (stage_q.rd != {REG_IDX_W{1'b0}});
  assign commit_s        = wb_pending & ~wb_stall;

  // A stall freezes the entry, valid bit included, so it commits exactly once later.
  always_comb begin
    stage_d = stage_q;
    if (wb_stall) begin
      stage_d = stage_q;
    end else if (wb.wb_valid_in) begin
      stage_d.valid = 1'b1;
      stage_d.ctrl  = wb.rd_write_control_in;
      stage_d.rd    = wb.rd_addr_in;
      stage_d.val   = wb.rd_write_val_in;
    end else begin
      stage_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  regfile_array u_array (
    .clk     (clk),
    .reset   (reset),
    .we      (commit_s),
    .waddr   (stage_q.rd),
    .wdata   (stage_q.val),
    .raddr_a (rs1_addr),
    .rdata_a (arr_rs1_s),
    .raddr_b (rs2_addr),
    .rdata_b (arr_rs2_s)
  );

  function automatic logic [XLEN-1:0] read_port(
    input logic [REG_IDX_W-1:0] idx,
    input wb_entry_t            st,
    input logic [XLEN-1:0]      arr_val
  );
    logic [XLEN-1:0] r;
    if (idx == {REG_IDX_W{1'b0}}) begin
      r = {XLEN{1'b0}};
    end else if (st.valid && st.ctrl && (st.rd == idx)) begin
      r = st.val;
    end else begin
      r = arr_val;
    end
    return r;
  endfunction

  assign rs1_val = read_port(rs1_addr, stage_q, arr_rs1_s);
  assign rs2_val = read_port(rs2_addr, stage_q, arr_rs2_s);

`ifdef WB_RETIRE_COUNT_EN
  logic [31:0] retire_q, retire_d;

  always_comb begin
    if (commit_s) begin
      retire_d = retire_q + 32'd1;
    end else begin
      retire_d = retire_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retire_q <= 32'd0;
    end else begin
      retire_q <= retire_d;
    end
  end

  assign retire_count = retire_q;
`else
  assign retire_count = 32'd0;
`endif
endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_stall;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_val, rs2_val;
  logic        wb_pending;
  logic [31:0] retire_count;
  int          n_cmp = 0;
  int          n_err = 0;

  wb_regfile_if wbif ();

  wb_regfile dut (
    .clk          (clk),
    .reset        (reset),
    .wb           (wbif),
    .wb_stall     (wb_stall),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_val      (rs1_val),
    .rs2_val      (rs2_val),
    .wb_pending   (wb_pending),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Expected counter value: only advances when the counter is built in.
  function automatic logic [31:0] exp_ret(input int n);
`ifdef WB_RETIRE_COUNT_EN
    return 32'(n);
`else
    return 32'd0 + 32'(n * 0);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic ctrl, input logic [31:0] val);
    wbif.wb_valid_in         = v;
    wbif.rd_addr_in          = rd;
    wbif.rd_write_control_in = ctrl;
    wbif.rd_write_val_in     = val;
  endtask

  initial begin
    reset = 1'b1; wb_stall = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd31;
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    tick(); tick();
    reset = 1'b0;
    #1;
    check_eq("rst_rs1", rs1_val, 32'd0);
    check_eq("rst_rs2", rs2_val, 32'd0);
    check_eq("rst_pend", {31'd0, wb_pending}, 32'd0);
    check_eq("rst_cnt", retire_count, 32'd0);
    check_eq("rst_ready", {31'd0, wbif.wb_ready_out}, 32'd1);

    // Single write: bypass next cycle, array the cycle after.
    drive(1'b1, 5'd3, 1'b1, 32'hDEADBEEF);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    rs1_addr = 5'd3;
    #1;
    check_eq("byp_rs1", rs1_val, 32'hDEADBEEF);
    check_eq("byp_pend", {31'd0, wb_pending}, 32'd1);
    check_eq("byp_cnt", retire_count, exp_ret(0));
    tick();
    check_eq("arr_rs1", rs1_val, 32'hDEADBEEF);
    check_eq("arr_pend", {31'd0, wb_pending}, 32'd0);
    check_eq("arr_cnt", retire_count, exp_ret(1));

    // Back-to-back writes to the same register.
    rs2_addr = 5'd7;
    drive(1'b1, 5'd7, 1'b1, 32'h1);
    tick();
    #1;
    check_eq("b2b_first", rs2_val, 32'h1);
    drive(1'b1, 5'd7, 1'b1, 32'h2);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    #1;
    check_eq("b2b_byp", rs2_val, 32'h2);
    check_eq("b2b_cnt_mid", retire_count, exp_ret(2));
    tick();
    check_eq("b2b_arr", rs2_val, 32'h2);
    check_eq("b2b_cnt", retire_count, exp_ret(3));
    check_eq("b2b_rs1_keep", rs1_val, 32'hDEADBEEF);

    // Writes to x0 and no-op entries leave no trace.
    drive(1'b1, 5'd0, 1'b1, 32'hFFFFFFFF);
    rs1_addr = 5'd0;
    tick();
    #1;
    check_eq("x0_rd", rs1_val, 32'd0);
    check_eq("x0_pend", {31'd0, wb_pending}, 32'd0);
    drive(1'b1, 5'd9, 1'b0, 32'h55);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    rs1_addr = 5'd9;
    #1;
    check_eq("nop_byp", rs1_val, 32'd0);
    check_eq("nop_pend", {31'd0, wb_pending}, 32'd0);
    tick();
    check_eq("nop_arr", rs1_val, 32'd0);
    check_eq("nop_cnt", retire_count, exp_ret(3));

    // Stall holds the entry; offered data during stall is ignored.
    rs1_addr = 5'd4;
    drive(1'b1, 5'd4, 1'b1, 32'hA5A5A5A5);
    tick();
    wb_stall = 1'b1;
    drive(1'b1, 5'd4, 1'b1, 32'h00000BAD);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("stl_ready", {31'd0, wbif.wb_ready_out}, 32'd0);
      check_eq("stl_byp", rs1_val, 32'hA5A5A5A5);
      check_eq("stl_pend", {31'd0, wb_pending}, 32'd1);
      check_eq("stl_cnt", retire_count, exp_ret(3));
    end
    wb_stall = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    #1;
    check_eq("rel_ready", {31'd0, wbif.wb_ready_out}, 32'd1);
    tick();
    check_eq("rel_arr", rs1_val, 32'hA5A5A5A5);
    check_eq("rel_pend", {31'd0, wb_pending}, 32'd0);
    check_eq("rel_cnt", retire_count, exp_ret(4));
    tick();
    check_eq("rel_nodup", retire_count, exp_ret(4));

    // Reset while an entry is pending discards it.
    rs1_addr = 5'd12;
    rs2_addr = 5'd4;
    drive(1'b1, 5'd12, 1'b1, 32'h1234);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    #1;
    check_eq("prst_byp", rs1_val, 32'h1234);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_eq("prst_rs1", rs1_val, 32'd0);
    check_eq("prst_rs2", rs2_val, 32'd0);
    check_eq("prst_pend", {31'd0, wb_pending}, 32'd0);
    check_eq("prst_cnt", retire_count, 32'd0);
    tick();
    check_eq("prst_rs1_late", rs1_val, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
